// File: rtl/tt_asiclab_pkg.sv
`default_nettype none
// ============================================================================
// Module : tt_asiclab_pkg
// Desc   : Shared pin-map constants, types and helpers for the nibble packer.
// Rev    : 1.0 - initial release
// ============================================================================
package tt_asiclab_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 2;

    // ui_in bit map
    localparam int c_ui_nibble_lsb = 0;
    localparam int c_ui_nibble_msb = 3;
    localparam int c_ui_in_valid   = 4;
    localparam int c_ui_out_ready  = 5;
    localparam int c_ui_flush      = 6;

    // uio_out bit map
    localparam int c_uio_out_valid = 0;
    localparam int c_uio_in_ready  = 1;
    localparam int c_uio_half      = 2;
    localparam int c_uio_zero      = 3;
    localparam int c_uio_sent_lsb  = 4;
    localparam int c_uio_sent_msb  = 7;

    localparam logic [7:0] c_uio_oe = 8'h0F;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;

    function automatic byte_t pack_pair(input nibble_t hi, input nibble_t lo);
        return {hi, lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/asiclab_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module : asiclab_byte_fifo
// Desc   : Small byte FIFO with simultaneous push/pop; the caller guarantees
//          no push when full and no pop when empty.
// Rev    : 1.0 - initial release
// ============================================================================
module asiclab_byte_fifo
    import tt_asiclab_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  byte_t                        i_data,
    input  logic                         i_pop,
    output byte_t                        o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    byte_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tt_um_asiclab_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module : tt_um_asiclab_nibble_packer
// Desc   : Packs nibble pairs into bytes (first nibble high) behind a small
//          byte FIFO, with flush of a lone nibble and a sent-byte counter.
// Rev    : 1.0 - initial release
// ============================================================================
module tt_um_asiclab_nibble_packer
    import tt_asiclab_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] c_full = CW'(FIFO_DEPTH);

    nibble_t         w_in_nibble;
    logic            w_in_valid;
    logic            w_out_ready;
    logic            w_flush;
    logic            w_unused_inputs;

    logic            r_half;
    nibble_t         r_hold;
    logic [3:0]      r_bytes_sent;

    logic [CW-1:0]   w_count;
    byte_t           w_head;
    byte_t           w_push_byte;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_pair_push;
    logic            w_flush_push;
    logic            w_push;
    logic            w_pop;

    assign w_in_nibble     = ui_in[c_ui_nibble_msb:c_ui_nibble_lsb];
    assign w_in_valid      = ui_in[c_ui_in_valid];
    assign w_out_ready     = ui_in[c_ui_out_ready];
    assign w_flush         = ui_in[c_ui_flush];
    assign w_unused_inputs = &{1'b0, ena, uio_in, ui_in[7]};

    // in_ready depends only on registered state so out_ready never reaches it
    assign w_in_ready   = !(r_half && (w_count == c_full));
    assign w_out_valid  = (w_count != '0);
    assign w_accept     = w_in_valid && w_in_ready;
    assign w_pair_push  = w_accept && r_half;
    assign w_flush_push = w_flush && r_half && !w_in_valid && (w_count < c_full);
    assign w_push       = w_pair_push || w_flush_push;
    assign w_pop        = w_out_valid && w_out_ready;
    assign w_push_byte  = pack_pair(r_hold, w_pair_push ? w_in_nibble : 4'h0);

    asiclab_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_byte),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half       <= 1'b0;
            r_hold       <= '0;
            r_bytes_sent <= '0;
        end else begin
            if (w_accept) begin
                r_half <= !r_half;
                if (!r_half) begin
                    r_hold <= w_in_nibble;
                end
            end else if (w_flush_push) begin
                r_half <= 1'b0;
            end
            if (w_pop) begin
                r_bytes_sent <= r_bytes_sent + 4'd1;
            end
        end
    end

    always_comb begin
        uio_out                                = '0;
        uio_out[c_uio_out_valid]               = w_out_valid;
        uio_out[c_uio_in_ready]                = w_in_ready;
        uio_out[c_uio_half]                    = r_half;
        uio_out[c_uio_zero]                    = 1'b0;
        uio_out[c_uio_sent_msb:c_uio_sent_lsb] = r_bytes_sent;
    end

    assign uo_out = w_out_valid ? w_head : 8'h00;
    assign uio_oe = c_uio_oe;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_asiclab_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_tt_um_asiclab_nibble_packer
// Desc   : Scoreboard bench: driver models the packer, monitor checks bytes.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tt_um_asiclab_nibble_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] m_fifo [$];
    logic       m_half;
    logic [3:0] m_hold;
    int         m_sent;

    tt_um_asiclab_nibble_packer #(.FIFO_DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_half = 1'b0;
        m_hold = 4'h0;
        m_sent = 0;
        m_fifo.delete();
        exp_q.delete();
    endtask

    // Effect of one rising edge given the inputs currently applied
    task automatic model_edge();
        logic [3:0] n;
        logic       v, r, f, rdy, push;
        logic [7:0] b;
        n    = ui_in[3:0];
        v    = ui_in[4];
        r    = ui_in[5];
        f    = ui_in[6];
        rdy  = !(m_half && m_fifo.size() == 2);
        push = 1'b0;
        b    = 8'h00;
        if (v && rdy) begin
            if (m_half) begin
                b      = {m_hold, n};
                push   = 1'b1;
                m_half = 1'b0;
            end else begin
                m_hold = n;
                m_half = 1'b1;
            end
        end else if (f && m_half && !v && m_fifo.size() < 2) begin
            b      = {m_hold, 4'h0};
            push   = 1'b1;
            m_half = 1'b0;
        end
        if (m_fifo.size() != 0 && r) begin
            void'(m_fifo.pop_front());
            m_sent++;
        end
        if (push) begin
            m_fifo.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // Called at posedge+1; applies inputs, checks status mid-cycle, advances model
    task automatic cycle(input logic [3:0] n, input logic v, input logic r, input logic f);
        ui_in = {1'b0, f, r, v, n};
        @(negedge clk);
        chk("out_valid",  {7'd0, uio_out[0]}, {7'd0, m_fifo.size() != 0});
        chk("in_ready",   {7'd0, uio_out[1]}, {7'd0, !(m_half && m_fifo.size() == 2)});
        chk("half",       {7'd0, uio_out[2]}, {7'd0, m_half});
        chk("bytes_sent", {4'd0, uio_out[7:4]}, 8'(m_sent % 16));
        chk("uio_bit3",   {7'd0, uio_out[3]}, 8'h00);
        if (!uio_out[0]) chk("uo_idle", uo_out, 8'h00);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: every byte handed over must be the oldest expected one
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && uio_out[0] && ui_in[5]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got %h expected none", uo_out);
            end else begin
                e = exp_q.pop_front();
                chk("byte_out", uo_out, e);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        model_reset();
        #1;
        chk("rst_uo_out",  uo_out,  8'h00);
        chk("rst_uio_out", uio_out, 8'h02);
        chk("uio_oe",      uio_oe,  8'h0F);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic pairing
        cycle(4'h3, 1, 1, 0);
        cycle(4'hA, 1, 1, 0);
        repeat (2) cycle(4'h0, 0, 1, 0);

        // backpressure: 6 offered, 5 held, 6 stalled
        for (int i = 1; i <= 6; i++) cycle(4'(i), 1, 0, 0);
        cycle(4'h6, 1, 0, 0);
        cycle(4'h6, 1, 1, 0);
        cycle(4'h6, 1, 1, 0);
        repeat (4) cycle(4'h0, 0, 1, 0);

        // flush of a lone nibble, idle flush, and input priority over flush
        cycle(4'h7, 1, 1, 0);
        cycle(4'h0, 0, 1, 1);
        repeat (2) cycle(4'h0, 0, 1, 0);
        cycle(4'h0, 0, 1, 1);
        cycle(4'h9, 1, 1, 0);
        cycle(4'h2, 1, 1, 1);
        repeat (2) cycle(4'h0, 0, 1, 0);

        // simultaneous push and pop at count 1
        cycle(4'h1, 1, 0, 0);
        cycle(4'h2, 1, 0, 0);
        cycle(4'h3, 1, 0, 0);
        cycle(4'h4, 1, 1, 0);
        repeat (3) cycle(4'h0, 0, 1, 0);

        // reset with half=1 and count=2
        for (int i = 1; i <= 5; i++) cycle(4'(i), 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_uo_out",  uo_out,  8'h00);
        chk("midrst_uio_out", uio_out, 8'h02);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_hold_uio", uio_out, 8'h02);
        rst = 1'b0;

        // 16 bytes popped: counter wraps back to zero
        for (int i = 0; i < 32; i++) cycle(4'($urandom_range(0, 15)), 1, 1, 0);
        repeat (3) cycle(4'h0, 0, 1, 0);
        chk("wrap_bytes_sent", {4'd0, uio_out[7:4]}, 8'h00);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)),
                  ($urandom % 4) != 0,
                  ($urandom % 3) != 0,
                  ($urandom % 5) == 0);
        end

        repeat (6) cycle(4'h0, 0, 1, 0);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_asiclab_nibble_packer.md
TT_UM_ASICLAB_NIBBLE_PACKER -- requirements
Module: tt_um_asiclab_nibble_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ui_in, input, 8 bits: [3:0] in_nibble, [4] in_valid, [5] out_ready, [6] flush, [7] unused.
REQ-004 SHALL have port uo_out, output, 8 bits: packed byte at FIFO head; high nibble = first nibble received, low nibble = second.
REQ-005 SHALL have port uio_in, input, 8 bits: unused.
REQ-006 SHALL have port uio_out, output, 8 bits: [0] out_valid, [1] in_ready, [2] half (first nibble held), [3] 0, [7:4] bytes_sent.
REQ-007 SHALL have port uio_oe, output, 8 bits: constant 8'h0F.
REQ-008 SHALL have port ena, input, 1 bit: ignored.
REQ-009 SHALL have parameter FIFO_DEPTH, default 2, meaning number of packed-byte entries held; only the value 2 is supported.

Function
REQ-010 SHALL accept a nibble on a rising edge when in_valid and in_ready are both 1.
REQ-011 SHALL store an accepted nibble in the hold register and set half when half=0.
REQ-012 SHALL, when half=1, push {hold, in_nibble} into the FIFO on the accepting edge and clear half.
REQ-013 SHALL drive in_ready = NOT(half AND count==2), from registers only, with no combinational path from out_ready.
REQ-014 SHALL drive out_valid = (count != 0).
REQ-015 SHALL drive uo_out = FIFO head when out_valid=1, else 8'h00.
REQ-016 SHALL pop the FIFO head on an edge where out_valid and out_ready are both 1.
REQ-017 SHALL increment bytes_sent (4 bits, wraps 15->0) on every pop.
REQ-018 SHALL raise out_valid in the cycle after the edge that completes a pair (latency 1 cycle from second nibble to byte visible).
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and keep FIFO order.
REQ-020 SHALL, when flush=1, half=1, in_valid=0 and count<2, push {hold, 4'h0} and clear half.
REQ-021 SHALL ignore flush when half=0, when count==2, or when in_valid=1, with the input taking priority in the last case.
REQ-022 SHALL keep FIFO order strict: bytes leave in completion order, and the FIFO never overflows or underflows.

Reset
REQ-023 SHALL, while rst=1, force half=0, hold=0, count=0, both FIFO pointers=0 and bytes_sent=0, giving uo_out=8'h00 and uio_out=8'h02 (in_ready=1).
REQ-024 SHALL discard, on rst asserted mid-operation, any held nibble and any queued bytes with no partial output.
REQ-025 SHALL accept input on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place the ui_in/uio_out bit-index constants and the FIFO_DEPTH default in the shared package tt_asiclab_pkg.
REQ-027 SHALL implement the FIFO as sub-module asiclab_byte_fifo (push, pop, data, count).
REQ-028 SHALL keep the packing state (half, hold), flush handling and bytes_sent counter in the top module.

Verification
REQ-029 SHALL cover basic pairing: nibbles 0x3 then 0xA with out_ready=1 -> uo_out=8'h3A and out_valid=1 for one cycle; bytes_sent=1.
REQ-030 SHALL cover backpressure: out_ready=0 while 6 nibbles 1..6 are offered -> bytes 8'h12 and 8'h34 queue, 5 is held, and in_ready=0 with 6 stalled; raising out_ready -> 8'h12, 8'h34, 8'h56 emitted in order.
REQ-031 SHALL cover flush: nibble 0x7, then flush=1 with in_valid=0 -> byte 8'h70 emitted and half=0; flush with half=0 -> no output.
REQ-032 SHALL cover simultaneous push/pop at count=1 -> count stays 1 and output order is preserved.
REQ-033 SHALL cover reset mid-operation: assert rst with half=1 and count=2 -> next cycle uo_out=8'h00, uio_out=8'h02.
REQ-034 SHALL cover counter wrap: 16 bytes popped -> bytes_sent returns to 0.
